// File: rtl/sram_model_pkg.sv
// ----------------------------------------------------------------------------
// sram_model_pkg
// Shared types and helpers for the parametrised 1RW + N-read SRAM model.
//   sramState_e : controller state (CLEAR while zeroising, READY otherwise)
//   COLL_CNT_W  : width of the saturating collision counter
//   ramDepth()  : number of words addressed by an address of given width
//   numWmasks() : number of write-mask lanes for a word/lane width pair
// ----------------------------------------------------------------------------
package sram_model_pkg;

    // Controller state: CLEAR zeroises the array after reset, READY serves
    // requests.
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } sramState_e;

    // The collision counter width is fixed so bus-side status registers can
    // rely on it regardless of the memory shape.
    localparam int COLL_CNT_W = 16;

    // Inverse of clog2: words reachable with addrWidth address bits.
    function automatic int ramDepth(input int addrWidth);
        return 2 ** addrWidth;
    endfunction

    // One mask bit per lane of maskGran bits.
    function automatic int numWmasks(input int dataWidth, input int maskGran);
        return dataWidth / maskGran;
    endfunction

endpackage

// File: rtl/sram_read_pipe.sv
// ----------------------------------------------------------------------------
// sram_read_pipe
// Data + valid latency pipeline for one SRAM read port, with output hold.
// The first register captures the read word at the request edge; with
// READ_LATENCY = 2 a second register stage follows. Each data register only
// loads when its valid is set, so the output data holds the last completed
// read while the valid is low.
// Ports:
//   i_clk    : clock
//   i_rst    : asynchronous active-high reset (clears data and valid)
//   i_valid  : a read is issued this cycle
//   i_data   : read word resolved for this request
//   o_valid  : a read completes this cycle
//   o_data   : read data, held between completions
// ----------------------------------------------------------------------------
module sram_read_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_stageValid;
    logic [DATA_WIDTH-1:0] r_stageData;

    // First stage: capture the resolved word at the request edge. The data
    // register only loads on a real read so it doubles as the hold register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stageValid <= 1'b0;
            r_stageData  <= '0;
        end else begin
            r_stageValid <= i_valid;
            if (i_valid) begin
                r_stageData <= i_data;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_outValid;
            logic [DATA_WIDTH-1:0] r_outData;

            // Extra output stage: delays data and valid by one more edge
            // without introducing bubbles between back-to-back reads.
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_outValid <= 1'b0;
                    r_outData  <= '0;
                end else begin
                    r_outValid <= r_stageValid;
                    if (r_stageValid) begin
                        r_outData <= r_stageData;
                    end
                end
            end

            assign o_valid = r_outValid;
            assign o_data  = r_outData;
        end else begin : g_lat1
            assign o_valid = r_stageValid;
            assign o_data  = r_stageData;
        end
    endgenerate

endmodule

// File: rtl/sram_1rwnr_sync.sv
// ----------------------------------------------------------------------------
// sram_1rwnr_sync
// Single-clock behavioural SRAM with one read/write port (port 0) and
// NUM_RPORTS read-only ports. Supports lane write masks, 1- or 2-cycle read
// latency, optional same-cycle write-to-read bypass, a saturating collision
// counter and a post-reset zeroisation sequence.
// Ports:
//   i_clk              : clock, all inputs sampled on its rising edge
//   i_rst              : asynchronous active-high reset
//   i_csb0             : port 0 chip select, active low
//   i_web0             : port 0 write enable, active low
//   i_wmask0           : port 0 lane write enables, active high
//   i_addr0            : port 0 address
//   i_din0             : port 0 write data
//   o_dout0            : port 0 read data (held between reads)
//   o_dout0_valid      : port 0 read completes this cycle
//   i_csb_r            : read-port chip selects, active low
//   i_addr_r           : read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   o_dout_r           : read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_dout_r_valid     : per read-port completion flags
//   o_busy             : zeroisation in progress, all requests ignored
//   o_collision_count  : saturating count of cycles with a read/write collision
// ----------------------------------------------------------------------------
module sram_1rwnr_sync
    import sram_model_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int ADDR_WIDTH     = 11,
    parameter  int MASK_GRAN      = 8,
    parameter  int NUM_RPORTS     = 1,
    parameter  int READ_LATENCY   = 1,
    parameter  int BYPASS         = 1,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int NUM_WMASKS     = numWmasks(DATA_WIDTH, MASK_GRAN)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_csb0,
    input  logic                             i_web0,
    input  logic [NUM_WMASKS-1:0]            i_wmask0,
    input  logic [ADDR_WIDTH-1:0]            i_addr0,
    input  logic [DATA_WIDTH-1:0]            i_din0,
    output logic [DATA_WIDTH-1:0]            o_dout0,
    output logic                             o_dout0_valid,
    input  logic [NUM_RPORTS-1:0]            i_csb_r,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] i_addr_r,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] o_dout_r,
    output logic [NUM_RPORTS-1:0]            o_dout_r_valid,
    output logic                             o_busy,
    output logic [COLL_CNT_W-1:0]            o_collision_count
);

    localparam int RAM_DEPTH = ramDepth(ADDR_WIDTH);

    // Illegal parameter combinations stop elaboration outright.
    generate
        if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_badGran
            $fatal(1, "sram_1rwnr_sync: DATA_WIDTH must be a multiple of MASK_GRAN");
        end
        if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_badLat
            $fatal(1, "sram_1rwnr_sync: READ_LATENCY must be 1 or 2");
        end
        if ((NUM_RPORTS < 1) || (NUM_RPORTS > 4)) begin : g_badPorts
            $fatal(1, "sram_1rwnr_sync: NUM_RPORTS must be in 1..4");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    sramState_e            r_state;
    logic [ADDR_WIDTH-1:0] r_clrAddr;
    logic                  r_busy;
    logic [COLL_CNT_W-1:0] r_collCount;

    logic                  w_ready;
    logic                  w_clearing;
    logic                  w_wrEn;
    logic                  w_rd0En;
    logic [DATA_WIDTH-1:0] w_bitMask;
    logic [DATA_WIDTH-1:0] w_oldWord0;
    logic [DATA_WIDTH-1:0] w_wrWord;
    logic                  w_memWe;
    logic [ADDR_WIDTH-1:0] w_memAddr;
    logic [DATA_WIDTH-1:0] w_memData;
    logic [NUM_RPORTS-1:0] w_collide;
    logic                  w_anyCollide;

    // Requests are only honoured when the controller is READY and reset is
    // not being held; rst gates the array too so no write slips in while the
    // reset line is asserted.
    assign w_ready    = (r_state == READY) && !i_rst;
    assign w_clearing = (r_state == CLEAR) && !i_rst;
    assign w_wrEn     = w_ready && !i_csb0 && !i_web0;
    assign w_rd0En    = w_ready && !i_csb0 &&  i_web0;

    // Expand the lane mask to a per-bit mask.
    always_comb begin
        w_bitMask = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            w_bitMask[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{i_wmask0[i]}};
        end
    end

    // The merged word is what the addressed location will hold after this
    // edge; a mask of zero simply rewrites the old word. Colliding reads
    // with bypass enabled return this same word.
    assign w_oldWord0 = r_mem[i_addr0];
    assign w_wrWord   = (w_oldWord0 & ~w_bitMask) | (i_din0 & w_bitMask);

    // The array has a single write port shared by zeroisation and port 0.
    assign w_memWe   = w_clearing || w_wrEn;
    assign w_memAddr = w_clearing ? r_clrAddr : i_addr0;
    assign w_memData = w_clearing ? '0 : w_wrWord;

    // Memory array: deliberately outside the reset domain, its contents are
    // only ever cleared by the zeroisation sequence.
    always_ff @(posedge i_clk) begin
        if (w_memWe) begin
            r_mem[w_memAddr] <= w_memData;
        end
    end

    // Controller FSM: after reset walk the clear address over the whole
    // array, writing one zero per cycle, then hand over to READY. The
    // wrap of r_clrAddr back to zero on the last word is intentional.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            r_clrAddr <= '0;
            r_busy    <= (CLEAR_ON_RESET != 0);
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clrAddr <= r_clrAddr + ADDR_WIDTH'(1);
                    if (r_clrAddr == ADDR_WIDTH'(RAM_DEPTH - 1)) begin
                        r_state <= READY;
                        r_busy  <= 1'b0;
                    end
                end
                READY: begin
                    r_state <= READY;
                end
                default: begin
                    r_state <= READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;

    // Port 0 read path: port 0 never reads and writes in the same cycle, so
    // it always sees the current stored word.
    sram_read_pipe #(
        .DATA_WIDTH  (DATA_WIDTH),
        .READ_LATENCY(READ_LATENCY)
    ) u_pipe0 (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(w_rd0En),
        .i_data (w_oldWord0),
        .o_valid(o_dout0_valid),
        .o_data (o_dout0)
    );

    // Read-only ports: collision and bypass are resolved here at the request
    // edge, ahead of any latency stages.
    generate
        for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
            logic [ADDR_WIDTH-1:0] w_rdAddr;
            logic                  w_rdEn;
            logic [DATA_WIDTH-1:0] w_rdOld;
            logic [DATA_WIDTH-1:0] w_rdData;

            assign w_rdAddr     = i_addr_r[k*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_rdEn       = w_ready && !i_csb_r[k];
            assign w_rdOld      = r_mem[w_rdAddr];
            assign w_collide[k] = w_wrEn && w_rdEn && (w_rdAddr == i_addr0);
            assign w_rdData     = ((BYPASS != 0) && w_collide[k]) ? w_wrWord : w_rdOld;

            sram_read_pipe #(
                .DATA_WIDTH  (DATA_WIDTH),
                .READ_LATENCY(READ_LATENCY)
            ) u_pipe (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_valid(w_rdEn),
                .i_data (w_rdData),
                .o_valid(o_dout_r_valid[k]),
                .o_data (o_dout_r[k*DATA_WIDTH +: DATA_WIDTH])
            );
        end
    endgenerate

    assign w_anyCollide = |w_collide;

    // Collision counter: one increment per cycle in which any read port hits
    // the address being written, sticking at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_collCount <= '0;
        end else if (w_anyCollide && (r_collCount != '1)) begin
            r_collCount <= r_collCount + COLL_CNT_W'(1);
        end
    end

    assign o_collision_count = r_collCount;

endmodule

// File: doc/sram_1rwnr_sync.md
Name: sram_1rwnr_sync

Overview:
Parametrised, single-clock behavioural SRAM with one read/write port (port 0) and NUM_RPORTS read-only ports. It succeeds the fixed 32x2048 1RW1R macro model. It adds configurable width, depth, mask granularity, read latency and read-port count, plus same-cycle write-to-read bypass, collision counting and a post-reset zeroisation sequence. It sits between the SoC bus adapters and the hardened macro, both as a simulation stand-in and as a synthesisable fallback.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of MASK_GRAN.
ADDR_WIDTH, 11, address bits; RAM_DEPTH = 2**ADDR_WIDTH.
MASK_GRAN, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/MASK_GRAN.
NUM_RPORTS, 1, number of read-only ports, 1..4.
READ_LATENCY, 1, posedges from request to data, 1 or 2.
BYPASS, 1, 1 = a same-cycle read of a written address returns new data; 0 = returns old data.
CLEAR_ON_RESET, 1, 1 = zero all words after reset.

Ports:
clk  in  1  single clock; all ports are sampled on its rising edge
rst  in  1  asynchronous, active-high reset
csb0  in  1  port 0 chip select, active low
web0  in  1  port 0 write enable, active low
wmask0  in  NUM_WMASKS  lane write enables, active high
addr0  in  ADDR_WIDTH  port 0 address
din0  in  DATA_WIDTH  port 0 write data
dout0  out  DATA_WIDTH  port 0 read data
dout0_valid  out  1  dout0 updated this cycle
csb_r  in  NUM_RPORTS  read-port chip selects, active low
addr_r  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
dout_r  out  NUM_RPORTS*DATA_WIDTH  read data, packed the same way as addr_r
dout_r_valid  out  NUM_RPORTS  per-port valid
busy  out  1  clear sequence in progress; all requests are ignored
collision_count  out  16  saturating count of read/write address collisions

Behaviour:
- Reset values: dout0=0, dout_r=0, dout0_valid=0, dout_r_valid=0, collision_count=0, busy=CLEAR_ON_RESET. Memory contents are not reset by rst itself.
- FSM states: CLEAR, READY.
  - rst asserted: state goes to CLEAR if CLEAR_ON_RESET=1, else READY.
  - CLEAR: writes 0 to clr_addr each cycle; clr_addr counts 0..RAM_DEPTH-1.
  - After the write to RAM_DEPTH-1, the FSM goes to READY and busy drops. busy is high for exactly RAM_DEPTH cycles after rst deasserts.
  - rst asserted mid-clear restarts the sequence from address 0.
- CLEAR: csb0 and csb_r are treated as inactive. No writes, no valids, and collision_count is not incremented.
- Write (READY, !csb0, !web0): at the posedge, mem[addr0] lane i is updated with din0 lane i for every wmask0[i]=1. wmask0=0 is a legal no-op write. dout0_valid is not asserted for a write.
- Port 0 read (READY, !csb0, web0): data is captured at the request edge. dout0 and dout0_valid=1 appear READ_LATENCY cycles after it, in a pipeline with no bubbles.
- Read port k (READY, !csb_r[k]): same timing as port 0, independent per port.
- Output hold: when no read completes in a cycle, the valid is 0 and dout holds its previous value. Outputs never go X.
- Collision: a write and a read on port k to the same address in the same cycle.
  - BYPASS=1: read returns the merged word (masked lanes from din0, other lanes from old mem).
  - BYPASS=0: read returns the pre-write word.
  - collision_count increments by 1 per cycle in which at least one read port collides, saturating at 16'hFFFF.
- Reads on several ports of the same address in one cycle are all legal and return the same data.
- READ_LATENCY=2 adds one register stage to data and valid only. Bypass and collision are resolved at the request edge.
- Parameter legality is checked at elaboration: DATA_WIDTH % MASK_GRAN == 0, READ_LATENCY in {1,2}, NUM_RPORTS in 1..4. A violation is a fatal error.

Decomposition:
- Package sram_model_pkg: state enum (CLEAR, READY), a depth function clog-inverse (2**ADDR_WIDTH), a NUM_WMASKS helper, and the COLL_CNT_W=16 constant.
- Sub-module sram_read_pipe: data+valid latency pipeline with output hold. It is instantiated NUM_RPORTS+1 times (port 0 and each read port).
- Top level holds the memory array, the write-merge/bypass logic, the FSM and the collision counter.

Test Plan:
- Clear: defaults, pulse rst for 3 cycles, then release → busy high for exactly 2048 cycles; then a read of addr 0x7FF returns 0x00000000 with dout0_valid 1 cycle later.
- Masked write: write 0xDEADBEEF mask 4'b1111 to 0x010, then 0x11223344 mask 4'b0101 to 0x010, then read on port 0 and port r0 → both return 0xDE22BE44.
- Bypass and collision: write 0xAAAA5555 mask 4'b0011 to 0x020 (old value 0) while r0 reads 0x020 → BYPASS=1 gives dout_r 0x00005555 and BYPASS=0 gives 0x00000000; collision_count goes 0→1.
- Latency: READ_LATENCY=2, NUM_RPORTS=2, back-to-back reads of 0x001, 0x002, 0x003 on all ports → valids high on cycles +2..+4 with data in order; dout holds the 0x003 data afterwards with valid=0.
- Reset mid-clear: assert rst at clear cycle 1000 → busy stays high and the sequence restarts; busy lasts 2048 cycles from the new release; requests issued during busy produce no valid and no memory change.
- Saturation: force 65540 collision cycles → collision_count holds at 16'hFFFF; then rst → 0.
